// File: rtl/l1c_inst_assoc.sv
// -----------------------------------------------------------------------------
// l1c_inst_assoc -- N-way set-associative, read-only L1 instruction cache.
//
// A fetch request is latched in IDLE and looked up one cycle later against all
// ways of the indexed set. Hits answer in LOOKUP. Misses refill one full line
// from the wrapper as a burst of WORDS_PER_LINE beats, install it in a victim
// way, and answer from the line buffer in RESP. Tag, data and valid storage are
// flop arrays inside this block.
//
// Victim choice is the lowest-index invalid way. When every way is valid, the
// per-set round-robin pointer selects the victim and then advances.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   core_req_i         fetch request
//   core_addr_i        fetch byte address (word aligned, stable while stalled)
//   flush_i            invalidate all lines (fence.i)
//   core_out_o         fetched instruction (zero unless answering)
//   core_wait_o        stall to the core
//   I_req_o, I_addr_o  refill request and line-aligned base address
//   I_out_i, I_wait_i  refill beat data; a beat is taken when I_wait_i=0
//
// Optional feature macro: L1C_INST_PERF_CNT_EN
//   Adds saturating 64-bit hit_cnt_o / miss_cnt_o counters of LOOKUP outcomes.
// -----------------------------------------------------------------------------
module l1c_inst_assoc #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int SETS           = 64,
   parameter int WAYS           = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] core_out_o,
   output logic              core_wait_o,
   output logic              I_req_o,
   output logic [ADDR_W-1:0] I_addr_o,
   input  logic [DATA_W-1:0] I_out_i,
   input  logic              I_wait_i
`ifdef L1C_INST_PERF_CNT_EN
   ,
   output logic [63:0]       hit_cnt_o,
   output logic [63:0]       miss_cnt_o
`endif
);

   localparam int BYTE_W = $clog2(DATA_W / 8);
   localparam int WSEL_W = $clog2(WORDS_PER_LINE);
   localparam int OFF_W  = WSEL_W + BYTE_W;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [TAG_W-1:0]    lat_tag_q, lat_tag_d;
   logic [IDX_W-1:0]    lat_idx_q, lat_idx_d;
   logic [WSEL_W-1:0]   lat_wsel_q, lat_wsel_d;
   logic [WSEL_W-1:0]   beat_q, beat_d;
   logic                flush_pend_q, flush_pend_d;

   logic [WAYS-1:0]     valid_q    [SETS];
   logic [TAG_W-1:0]    tag_arr_q  [SETS][WAYS];
   logic [DATA_W-1:0]   data_arr_q [SETS][WAYS][WORDS_PER_LINE];
   logic [DATA_W-1:0]   line_buf_q [WORDS_PER_LINE];

   logic                hit;
   logic [WAY_W-1:0]    hit_way;
   logic [DATA_W-1:0]   hit_word;
   logic                inv_found;
   logic [WAY_W-1:0]    inv_way;
   logic [WAY_W-1:0]    rr_sel;
   logic [WAY_W-1:0]    victim;
   logic                beat_we, fill, clr_valid;

   // Byte-offset bits below a word are never used for selection.
   generate
      if (BYTE_W > 0) begin : g_lsb
         logic unused_addr_lsbs;
         assign unused_addr_lsbs = ^core_addr_i[BYTE_W-1:0];
      end
   endgenerate

   // Tag compare across all ways of the latched set.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[lat_idx_q][w] && (tag_arr_q[lat_idx_q][w] == lat_tag_q)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end
   assign hit_word = data_arr_q[lat_idx_q][hit_way][lat_wsel_q];

   // Downward scan so the lowest-index invalid way wins.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[lat_idx_q][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end
   assign victim = inv_found ? inv_way : rr_sel;

   // Per-set round-robin pointers; only fills into a fully valid set advance them.
   generate
      if (WAYS > 1) begin : g_rr
         logic [SETS*WAY_W-1:0] rr_flat;
         for (genvar gi = 0; gi < SETS; gi++) begin : g_set
            logic [WAY_W-1:0] rr_q;
            always_ff @(posedge clk or posedge rst) begin
               if (rst)
                  rr_q <= '0;
               else if (fill && !inv_found && (lat_idx_q == IDX_W'(gi)))
                  rr_q <= rr_q + 1'b1;
            end
            assign rr_flat[gi*WAY_W +: WAY_W] = rr_q;
         end
         assign rr_sel = rr_flat[int'(lat_idx_q)*WAY_W +: WAY_W];
      end else begin : g_dm
         assign rr_sel = '0;
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      lat_tag_d    = lat_tag_q;
      lat_idx_d    = lat_idx_q;
      lat_wsel_d   = lat_wsel_q;
      beat_d       = beat_q;
      flush_pend_d = flush_pend_q | flush_i;
      core_out_o   = '0;
      core_wait_o  = 1'b0;
      I_req_o      = 1'b0;
      I_addr_o     = '0;
      beat_we      = 1'b0;
      fill         = 1'b0;
      clr_valid    = 1'b0;
      case (state_q)
         S_IDLE: begin
            core_wait_o  = core_req_i;
            // A flush deferred from a busy state lands here together with any new one.
            clr_valid    = flush_i | flush_pend_q;
            flush_pend_d = 1'b0;
            if (!flush_i && core_req_i) begin
               lat_tag_d  = core_addr_i[ADDR_W-1 -: TAG_W];
               lat_idx_d  = core_addr_i[OFF_W +: IDX_W];
               lat_wsel_d = core_addr_i[BYTE_W +: WSEL_W];
               state_d    = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               core_out_o = hit_word;
               state_d    = S_IDLE;
            end else begin
               core_wait_o = 1'b1;
               beat_d      = '0;
               state_d     = S_REFILL;
            end
         end
         S_REFILL: begin
            core_wait_o = 1'b1;
            I_req_o     = 1'b1;
            I_addr_o    = {lat_tag_q, lat_idx_q, {OFF_W{1'b0}}};
            if (!I_wait_i) begin
               beat_we = 1'b1;
               beat_d  = beat_q + 1'b1;
               if (beat_q == WSEL_W'(WORDS_PER_LINE - 1)) begin
                  fill    = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            core_out_o = line_buf_q[lat_wsel_q];
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lat_tag_q    <= '0;
         lat_idx_q    <= '0;
         lat_wsel_q   <= '0;
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
         for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else begin
         state_q      <= state_d;
         lat_tag_q    <= lat_tag_d;
         lat_idx_q    <= lat_idx_d;
         lat_wsel_q   <= lat_wsel_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
         if (clr_valid)
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
         else if (fill)
            valid_q[lat_idx_q][victim] <= 1'b1;
      end
   end

   // Payload storage needs no reset: nothing is visible until its valid bit is set.
   // The final beat bypasses the line buffer straight into the array.
   always_ff @(posedge clk) begin
      if (beat_we) line_buf_q[beat_q] <= I_out_i;
      if (fill) begin
         tag_arr_q[lat_idx_q][victim] <= lat_tag_q;
         for (int i = 0; i < WORDS_PER_LINE - 1; i++)
            data_arr_q[lat_idx_q][victim][i] <= line_buf_q[i];
         data_arr_q[lat_idx_q][victim][WORDS_PER_LINE-1] <= I_out_i;
      end
   end

`ifdef L1C_INST_PERF_CNT_EN
   logic [63:0] hit_cnt_q, miss_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == S_LOOKUP) begin
         if (hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 64'd1;
         if (!hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 64'd1;
      end
   end
   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1c_inst_assoc.sv
// -----------------------------------------------------------------------------
// tb_l1c_inst_assoc -- directed and randomized fetch sequences checked against
// a set/way/round-robin reference model of the cache contents and an address
// hash standing in for backing memory.
// -----------------------------------------------------------------------------
module tb_l1c_inst_assoc;
   localparam int SETS = 64;
   localparam int WAYS = 2;
   localparam int WPL  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req_i;
   logic [31:0] core_addr_i;
   logic        flush_i;
   logic [31:0] core_out_o;
   logic        core_wait_o;
   logic        I_req_o;
   logic [31:0] I_addr_o;
   logic [31:0] I_out_i;
   logic        I_wait_i;
`ifdef L1C_INST_PERF_CNT_EN
   logic [63:0] hit_cnt_o, miss_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   l1c_inst_assoc dut (
      .clk(clk), .rst(rst),
      .core_req_i(core_req_i), .core_addr_i(core_addr_i), .flush_i(flush_i),
      .core_out_o(core_out_o), .core_wait_o(core_wait_o),
      .I_req_o(I_req_o), .I_addr_o(I_addr_o),
      .I_out_i(I_out_i), .I_wait_i(I_wait_i)
`ifdef L1C_INST_PERF_CNT_EN
      , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Backing memory content: a fixed hash of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: per set, which line tags are resident and the RR pointer.
   bit          m_valid [SETS][WAYS];
   logic [31:0] m_tag   [SETS][WAYS];
   int          m_rr    [SETS];
   int          exp_hits, exp_misses;

   task automatic model_flush();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
   endtask

   task automatic model_reset();
      model_flush();
      for (int s = 0; s < SETS; s++) m_rr[s] = 0;
      exp_hits = 0;
      exp_misses = 0;
   endtask

   task automatic model_access(input logic [31:0] a, output bit is_hit);
      int s, v;
      logic [31:0] t;
      s = int'((a / (WPL * 4)) % SETS);
      t = a / (WPL * 4 * SETS);
      is_hit = 0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) is_hit = 1;
      if (!is_hit) begin
         v = -1;
         for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w] && v < 0) v = w;
         if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
         end
         m_valid[s][v] = 1;
         m_tag[s][v] = t;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wrapper responder: 0 = never waits, 1 = waits on alternate cycles starting
   // with a wait, 2 = random waits. Beat data follows the wrapper's own beat count.
   int wait_mode = 0;
   int tb_beat = 0;
   initial begin
      logic acc;
      bit   tog;
      tog = 1;
      I_wait_i = 1'b0;
      I_out_i = '0;
      forever begin
         @(negedge clk);
         acc = I_req_o && !I_wait_i;
         @(posedge clk);
         #1;
         if (!I_req_o) begin
            tb_beat = 0;
            tog = 1;
            I_wait_i = 1'b0;
         end else begin
            if (acc) tb_beat = (tb_beat + 1) % WPL;
            case (wait_mode)
               1:       I_wait_i = tog;
               2:       I_wait_i = 1'($urandom % 2);
               default: I_wait_i = 1'b0;
            endcase
            tog = !tog;
         end
         I_out_i = mem_word(I_addr_o + 32'(tb_beat * 4));
      end
   end

   // One fetch. fmode: 0 plain, 1 flush raised together with the request,
   // 2 flush pulsed during the refill.
   task automatic do_fetch(input logic [31:0] a, input int fmode, input string nm);
      logic [31:0] got, iaddr;
      int  lat, nreq, nwait, zbad, mode;
      bit  done, pulsed, exp_hit;
      got = '0; iaddr = '0; lat = 0; nreq = 0; nwait = 0; zbad = 0;
      done = 0; pulsed = 0; mode = fmode;
      if (mode == 1) model_flush();
      model_access(a, exp_hit);
      if (mode == 2 && exp_hit) mode = 0;
      if (exp_hit) exp_hits++; else exp_misses++;
      core_req_i = 1'b1;
      core_addr_i = a;
      flush_i = (mode == 1);
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         if (I_req_o) begin
            nreq++;
            iaddr = I_addr_o;
            if (I_wait_i) nwait++;
         end
         if (!core_wait_o) begin
            got = core_out_o;
            done = 1;
         end else if (core_out_o !== '0) begin
            zbad++;
         end
         @(posedge clk);
         #1;
         flush_i = 1'b0;
         if (!done && mode == 2 && I_req_o && !pulsed) begin
            flush_i = 1'b1;
            pulsed = 1;
         end
      end
      core_req_i = 1'b0;
      flush_i = 1'b0;
      if (mode == 2) model_flush();
      chk({nm, "_done"}, 64'(done), 64'd1);
      chk({nm, "_data"}, 64'(got), 64'(mem_word(a)));
      chk({nm, "_ireq_cycles"}, 64'(nreq), exp_hit ? 64'd0 : 64'(WPL + nwait));
      chk({nm, "_latency"}, 64'(lat),
          exp_hit ? 64'd2 : 64'(3 + WPL + nwait + int'(mode == 1)));
      if (!exp_hit) chk({nm, "_iaddr"}, 64'(iaddr), 64'(a & ~32'(WPL * 4 - 1)));
      chk({nm, "_out_zero_while_wait"}, 64'(zbad), 64'd0);
      if (mode == 2) chk({nm, "_flush_pulsed"}, 64'(pulsed), 64'd1);
      $display("fetch %s addr=%08h data=%08h lat=%0d %s", nm, a, got, lat,
               exp_hit ? "hit" : "miss");
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      core_req_i = 1'b0;
      core_addr_i = '0;
      flush_i = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_core_out", 64'(core_out_o), 64'd0);
      chk("rst_core_wait", 64'(core_wait_o), 64'd0);
      chk("rst_i_req", 64'(I_req_o), 64'd0);
      chk("rst_i_addr", 64'(I_addr_o), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Cold miss, then a hit on the same line.
      wait_mode = 0;
      do_fetch(32'h0001_0004, 0, "cold_miss");
      do_fetch(32'h0001_0008, 0, "line_hit");

      // Three lines into set 0 of a two-way cache.
      do_fetch(32'h0002_0000, 0, "fill_b");
      do_fetch(32'h0003_0000, 0, "fill_c_evict");
      do_fetch(32'h0002_0000, 0, "b_hit");
      do_fetch(32'h0001_0000, 0, "a_evicted");
`ifdef L1C_INST_PERF_CNT_EN
      chk("perf_hits", hit_cnt_o, 64'(exp_hits));
      chk("perf_misses", miss_cnt_o, 64'(exp_misses));
`endif

      // Refill with alternate-cycle wrapper waits.
      wait_mode = 1;
      do_fetch(32'h0004_0010, 0, "alt_wait_miss");
      do_fetch(32'h0004_001C, 0, "alt_wait_hit");
      wait_mode = 0;

      // Flush interactions.
      do_fetch(32'h0002_0000, 1, "flush_with_req");
      do_fetch(32'h0005_0020, 2, "flush_in_refill");
      do_fetch(32'h0005_0024, 0, "after_flush_refetch");

      // Reset in the middle of a refill.
      core_req_i = 1'b1;
      core_addr_i = 32'h0006_0040;
      n = 0;
      while (tb_beat < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_two_beats", 64'(tb_beat), 64'd2);
      chk("rst_mid_ireq_before", 64'(I_req_o), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_ireq_async", 64'(I_req_o), 64'd0);
      chk("rst_mid_iaddr_async", 64'(I_addr_o), 64'd0);
      core_req_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_fetch(32'h0006_0040, 0, "after_rst_partial");
      do_fetch(32'h0004_0010, 0, "after_rst_old_line");

      // Randomized traffic over a small footprint to force hits and evictions.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         int fm;
         a = (32'(1 + $urandom % 3) << 16) | (32'($urandom % 4) << 4) | (32'($urandom % 4) << 2);
         wait_mode = int'($urandom % 3);
         n = int'($urandom % 10);
         fm = (n == 0) ? 1 : (n == 1) ? 2 : 0;
         do_fetch(a, fm, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
